limn2600_mem_arbiter: RTL

//  Two-requester arbiter/sequencer for the single Limn2600 RAM port. Shares the port between

---
 rtl/limn2600_mem_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/limn2600_mem_arbiter.sv
// Shares the single Limn2600 RAM port between instruction fetch and load/store, with RMW for sub-word stores.
// Build option: define LIMN_ARB_ROUND_ROBIN_EN for round-robin arbitration instead of LS priority with starvation limit.
module limn2600_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_data_out_o,
  input  logic [31:0] ram_data_in_i,
  output logic        ram_we_o,
  output logic        ram_ce_o,
  input  logic        ram_rdy_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_rdy_o,
  output logic [31:0] if_data_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [1:0]  ls_size_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_rdy_o,
  output logic [31:0] ls_rdata_o,
  output logic        busy_o
);

  // states: IDLE arbitrate | ACC word access | RMW_RD/RMW_WR sub-word merge | RESP rdy pulse
  typedef enum logic [2:0] {S_IDLE, S_ACC, S_RMW_RD, S_RMW_WR, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        port_ls_q, port_ls_d;
  logic        grant_ls, grant_if;

`ifdef LIMN_ARB_ROUND_ROBIN_EN
  logic        last_ls_q, last_ls_d;
`else
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_q, starve_d;
`endif

  function automatic logic [31:0] merge_f(input logic [31:0] old, input logic [15:0] wd,
                                          input logic half, input logic [1:0] a);
    logic [31:0] r;
    r = old;
    if (!half) r[{a, 3'b000} +: 8] = wd[7:0];
    else       r[{a[1], 4'b0000} +: 16] = wd;
    return r;
  endfunction

  function automatic logic [31:0] extract_f(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] a);
    case (sz)
      2'b00:   return {24'b0, w[{a, 3'b000} +: 8]};
      2'b01:   return {16'b0, w[{a[1], 4'b0000} +: 16]};
      default: return w;
    endcase
  endfunction

  always_comb begin
    grant_ls = 1'b0;
    grant_if = 1'b0;
`ifdef LIMN_ARB_ROUND_ROBIN_EN
    if (ls_req_i && if_req_i) begin
      grant_ls = !last_ls_q;
      grant_if = last_ls_q;
    end else begin
      grant_ls = ls_req_i;
      grant_if = if_req_i;
    end
`else
    if (if_req_i && (starve_q == CW'(STARVE_LIMIT))) grant_if = 1'b1;
    else if (ls_req_i)                              grant_ls = 1'b1;
    else                                            grant_if = if_req_i;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      data_q    <= '0;
      size_q    <= '0;
      we_q      <= 1'b0;
      port_ls_q <= 1'b0;
`ifdef LIMN_ARB_ROUND_ROBIN_EN
      last_ls_q <= 1'b0;
`else
      starve_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      data_q    <= data_d;
      size_q    <= size_d;
      we_q      <= we_d;
      port_ls_q <= port_ls_d;
`ifdef LIMN_ARB_ROUND_ROBIN_EN
      last_ls_q <= last_ls_d;
`else
      starve_q  <= starve_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    data_d    = data_q;
    size_d    = size_q;
    we_d      = we_q;
    port_ls_d = port_ls_q;
`ifdef LIMN_ARB_ROUND_ROBIN_EN
    last_ls_d = last_ls_q;
`else
    starve_d  = starve_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_ls || grant_if) begin
          port_ls_d = grant_ls;
          addr_d    = grant_ls ? ls_addr_i : if_addr_i;
          we_d      = grant_ls && ls_we_i;
          size_d    = grant_ls ? ls_size_i : 2'b10;
          wdata_d   = grant_ls ? ls_wdata_i : 32'h0;
          state_d   = (grant_ls && ls_we_i && !ls_size_i[1]) ? S_RMW_RD : S_ACC;
`ifdef LIMN_ARB_ROUND_ROBIN_EN
          last_ls_d = grant_ls;
`else
          if (grant_if || !if_req_i) starve_d = '0;
          else                       starve_d = starve_q + 1'b1;
`endif
        end
      end
      S_ACC: begin
        if (ram_rdy_i) begin
          data_d  = ram_data_in_i;
          state_d = S_RESP;
        end
      end
      S_RMW_RD: begin
        if (ram_rdy_i) begin
          data_d  = merge_f(ram_data_in_i, wdata_q[15:0], size_q[0], addr_q[1:0]);
          state_d = S_RMW_WR;
        end
      end
      S_RMW_WR: begin
        if (ram_rdy_i) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ram_ce_o       = (state_q == S_ACC) || (state_q == S_RMW_RD) || (state_q == S_RMW_WR);
    ram_we_o       = ((state_q == S_ACC) && we_q) || (state_q == S_RMW_WR);
    ram_addr_o     = ram_ce_o ? {addr_q[31:2], 2'b00} : 32'h0;
    ram_data_out_o = 32'h0;
    if ((state_q == S_ACC) && we_q) ram_data_out_o = wdata_q;
    else if (state_q == S_RMW_WR)   ram_data_out_o = data_q;
    if_rdy_o       = (state_q == S_RESP) && !port_ls_q;
    ls_rdy_o       = (state_q == S_RESP) && port_ls_q;
    if_data_o      = if_rdy_o ? data_q : 32'h0;
    ls_rdata_o     = (ls_rdy_o && !we_q) ? extract_f(data_q, size_q, addr_q[1:0]) : 32'h0;
    busy_o         = (state_q != S_IDLE);
  end

endmodule
